// File: rtl/pixel_arith_pipe.sv
// Two-stage per-channel pixel arithmetic (saturating/bitwise ops against a frame-constant operand).
// Optional: define PIXEL_ARITH_SAT_CNT_EN to add the per-frame clamp counter output sat_count.
module pixel_arith_pipe #(
  parameter int DW  = 8,
  parameter int NCH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [3:0]        cfg_op,
  input  logic [DW-1:0]     cfg_value,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [NCH*DW-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic [NCH*DW-1:0] out_data,
  output logic [NCH-1:0]    out_sat,
  output logic              busy
`ifdef PIXEL_ARITH_SAT_CNT_EN
  ,
  output logic [31:0]       sat_count
`endif
);

  typedef enum logic [3:0] {
    OP_ADD     = 4'd0,
    OP_SUB     = 4'd1,
    OP_MUL     = 4'd2,
    OP_SHR     = 4'd3,
    OP_AND     = 4'd4,
    OP_OR      = 4'd5,
    OP_NOT     = 4'd6,
    OP_ABSDIFF = 4'd7,
    OP_THRESH  = 4'd8,
    OP_PASS    = 4'd15
  } op_e;

  op_e                r_act_op;
  logic [DW-1:0]      r_act_val;
  logic               r_s1_valid;
  logic               r_s1_sof;
  logic [NCH*DW-1:0]  r_s1_data;
  op_e                r_s1_op;
  logic [DW-1:0]      r_s1_val;
  logic               r_s2_valid;
  logic               r_s2_sof;
  logic [NCH*DW-1:0]  r_s2_data;
  logic [NCH-1:0]     r_s2_sat;

  logic               w_s1_ready;
  logic               w_s2_ready;
  logic               w_cfg_load;
  op_e                w_new_op;
  op_e                w_beat_op;
  logic [DW-1:0]      w_beat_val;
  logic [NCH*DW-1:0]  w_res;
  logic [NCH-1:0]     w_sat;

  // Returns {clamped, result} for one channel.
  function automatic logic [DW:0] f_calc(input op_e op, input logic [DW-1:0] x,
                                         input logic [DW-1:0] v);
    logic [DW:0]      sum;
    logic [2*DW-1:0]  prod;
    logic [DW-1:0]    r;
    logic             s;
    sum  = {1'b0, x} + {1'b0, v};
    prod = {{DW{1'b0}}, x} * {{DW{1'b0}}, v};
    r    = x;
    s    = 1'b0;
    case (op)
      OP_ADD:     begin s = sum[DW];               r = s ? '1 : sum[DW-1:0];  end
      OP_SUB:     begin s = (x < v);               r = s ? '0 : x - v;        end
      OP_MUL:     begin s = |prod[2*DW-1:DW];      r = s ? '1 : prod[DW-1:0]; end
      OP_SHR:     r = (int'(v) >= DW) ? '0 : x >> v;
      OP_AND:     r = x & v;
      OP_OR:      r = x | v;
      OP_NOT:     r = ~x;
      OP_ABSDIFF: r = (x >= v) ? x - v : v - x;
      OP_THRESH:  r = (x >= v) ? '1 : '0;
      default:    r = x;
    endcase
    return {s, r};
  endfunction

  assign w_s2_ready = !r_s2_valid | out_ready;
  assign w_s1_ready = !r_s1_valid | w_s2_ready;
  assign in_ready   = w_s1_ready;
  assign w_cfg_load = in_valid & w_s1_ready & in_sof;
  assign w_new_op   = (enable && cfg_op <= 4'd8) ? op_e'(cfg_op) : OP_PASS;
  // The SOF beat itself already uses the freshly loaded configuration.
  assign w_beat_op  = w_cfg_load ? w_new_op  : r_act_op;
  assign w_beat_val = w_cfg_load ? cfg_value : r_act_val;

  always_comb begin
    w_res = '0;
    w_sat = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      {w_sat[c], w_res[c*DW +: DW]} = f_calc(r_s1_op, r_s1_data[c*DW +: DW], r_s1_val);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_op   <= OP_PASS;
      r_act_val  <= '0;
      r_s1_valid <= 1'b0;
      r_s1_sof   <= 1'b0;
      r_s1_data  <= '0;
      r_s1_op    <= OP_PASS;
      r_s1_val   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_sof   <= 1'b0;
      r_s2_data  <= '0;
      r_s2_sat   <= '0;
    end else begin
      if (w_cfg_load) begin
        r_act_op  <= w_new_op;
        r_act_val <= cfg_value;
      end
      if (w_s1_ready) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_sof  <= in_sof;
          r_s1_data <= in_data;
          r_s1_op   <= w_beat_op;
          r_s1_val  <= w_beat_val;
        end
      end
      if (w_s2_ready) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_sof  <= r_s1_sof;
          r_s2_data <= w_res;
          r_s2_sat  <= w_sat;
        end
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_sof   = r_s2_sof;
  assign out_data  = r_s2_data;
  assign out_sat   = r_s2_sat;
  assign busy      = r_s1_valid | r_s2_valid;

`ifdef PIXEL_ARITH_SAT_CNT_EN
  logic [31:0] r_sat_cnt;
  logic [31:0] w_pop;
  logic [32:0] w_cnt_sum;

  always_comb begin
    w_pop = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      w_pop = w_pop + 32'(r_s2_sat[c]);
    end
    w_cnt_sum = {1'b0, r_sat_cnt} + {1'b0, w_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_cnt <= '0;
    end else if (r_s2_valid && out_ready) begin
      if (r_s2_sof) r_sat_cnt <= w_pop;
      else          r_sat_cnt <= w_cnt_sum[32] ? '1 : w_cnt_sum[31:0];
    end
  end

  assign sat_count = r_sat_cnt;
`endif

endmodule
